// File: rtl/abr_params_pkg.sv
`default_nettype none
// ============================================================================
// Module      : abr_params_pkg
// Description : Shared types and defaults for the ABR sample memory writer.
//               Holds the writer FSM state encoding, the polynomial size
//               default and the coefficient type.
// Revision    : 1.0 - initial release
// ============================================================================
package abr_params_pkg;

  localparam int DEFAULT_COEFF_PER_POLY = 256;
  localparam int DEFAULT_DATA_W         = 24;

  typedef logic [DEFAULT_DATA_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    SMW_IDLE = 2'd0,
    SMW_RUN  = 2'd1,
    SMW_DONE = 2'd2
  } smw_state_e;

endpackage : abr_params_pkg
`default_nettype wire

// File: rtl/abr_sample_mem_writer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : abr_sample_mem_writer_ctrl
// Description : Run control for the sample memory writer. Owns the FSM, the
//               word/poly counters and the write address register.
// Ports       : clk, rst_b (async, active-low), zeroize (sync clear)
//               start_i, base_addr_i, num_poly_i  - run setup
//               data_valid_i                      - input word valid
//               accept_o      - word is written this cycle
//               addr_o        - address for the accepted word
//               last_word_o   - accepted word closes a polynomial
//               final_o       - accepted word closes the whole run
//               busy_o, sampler_stop_o            - status
// Revision    : 1.0 - initial release
// ============================================================================
module abr_sample_mem_writer_ctrl
  import abr_params_pkg::*;
#(
  parameter int NUM_RD         = 4,
  parameter int ADDR_W         = 10,
  parameter int COEFF_PER_POLY = DEFAULT_COEFF_PER_POLY
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              zeroize,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [2:0]        num_poly_i,
  input  logic              data_valid_i,
  output logic              accept_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_word_o,
  output logic              final_o,
  output logic              busy_o,
  output logic              sampler_stop_o
);

  localparam int WORDS_PER_POLY = COEFF_PER_POLY / NUM_RD;
  // Keep the counter at least one bit wide for degenerate one-word polys.
  localparam int WCNT_W = (WORDS_PER_POLY > 1) ? $clog2(WORDS_PER_POLY) : 1;
  localparam logic [WCNT_W-1:0] c_last_word = WCNT_W'(WORDS_PER_POLY - 1);

  smw_state_e        r_state;
  smw_state_e        w_state_nxt;
  logic [WCNT_W-1:0] r_word_cnt;
  logic [2:0]        r_poly_cnt;
  logic [2:0]        r_poly_lim;
  logic [ADDR_W-1:0] r_addr;
  logic              w_accept;
  logic              w_last_word;
  logic              w_final;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last_word = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      SMW_IDLE: begin
        if (start_i) begin
          w_state_nxt = SMW_RUN;
        end
      end
      SMW_RUN: begin
        if (data_valid_i) begin
          w_accept    = 1'b1;
          w_last_word = (r_word_cnt == c_last_word);
          w_final     = w_last_word && (r_poly_cnt == r_poly_lim);
          if (w_final) begin
            w_state_nxt = SMW_DONE;
          end
        end
      end
      SMW_DONE: begin
        w_state_nxt = SMW_IDLE;
      end
      default: begin
        w_state_nxt = SMW_IDLE;
      end
    endcase
    // Zeroize wins over everything, including a start or an accepted word.
    if (zeroize) begin
      w_state_nxt = SMW_IDLE;
      w_accept    = 1'b0;
      w_last_word = 1'b0;
      w_final     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= SMW_IDLE;
      r_word_cnt <= '0;
      r_poly_cnt <= '0;
      r_poly_lim <= '0;
      r_addr     <= '0;
    end else if (zeroize) begin
      r_state    <= SMW_IDLE;
      r_word_cnt <= '0;
      r_poly_cnt <= '0;
      r_poly_lim <= '0;
      r_addr     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == SMW_IDLE && start_i) begin
        r_addr     <= base_addr_i;
        r_poly_lim <= num_poly_i;
        r_word_cnt <= '0;
        r_poly_cnt <= '0;
      end else if (w_accept) begin
        // Address wraps silently modulo 2^ADDR_W.
        r_addr <= r_addr + ADDR_W'(1);
        if (w_last_word) begin
          r_word_cnt <= '0;
          r_poly_cnt <= r_poly_cnt + 3'd1;
        end else begin
          r_word_cnt <= r_word_cnt + WCNT_W'(1);
        end
      end
    end
  end

  assign accept_o       = w_accept;
  assign addr_o         = r_addr;
  assign last_word_o    = w_last_word;
  assign final_o        = w_final;
  assign busy_o         = (r_state != SMW_IDLE);
  assign sampler_stop_o = (r_state != SMW_RUN);

endmodule : abr_sample_mem_writer_ctrl
`default_nettype wire

// File: rtl/abr_sample_mem_writer.sv
`default_nettype none
// ============================================================================
// Module      : abr_sample_mem_writer
// Description : Writes packed NUM_RD-coefficient words from abr_sample_buffer
//               into polynomial memory at consecutive addresses, counts
//               completed polynomials and throttles the upstream sampler.
// Ports       : clk, rst_b (async, active-low), zeroize (sync clear)
//               start_i, base_addr_i, num_poly_i - run setup
//               data_valid_i, data_i             - buffer output word
//               mem_we_o, mem_addr_o, mem_wdata_o - memory write port
//               busy_o, sampler_stop_o           - status
//               poly_done_o, done_o              - completion pulses
// Revision    : 1.0 - initial release
// ============================================================================
module abr_sample_mem_writer
  import abr_params_pkg::*;
#(
  parameter int NUM_RD         = 4,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int ADDR_W         = 10,
  parameter int COEFF_PER_POLY = DEFAULT_COEFF_PER_POLY
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     zeroize,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic [2:0]               num_poly_i,
  input  logic                     data_valid_i,
  input  logic [NUM_RD*DATA_W-1:0] data_i,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [NUM_RD*DATA_W-1:0] mem_wdata_o,
  output logic                     busy_o,
  output logic                     sampler_stop_o,
  output logic                     poly_done_o,
  output logic                     done_o
);

  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last_word;
  logic              w_final;

  abr_sample_mem_writer_ctrl #(
    .NUM_RD         (NUM_RD),
    .ADDR_W         (ADDR_W),
    .COEFF_PER_POLY (COEFF_PER_POLY)
  ) u_ctrl (
    .clk            (clk),
    .rst_b          (rst_b),
    .zeroize        (zeroize),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .num_poly_i     (num_poly_i),
    .data_valid_i   (data_valid_i),
    .accept_o       (w_accept),
    .addr_o         (w_addr),
    .last_word_o    (w_last_word),
    .final_o        (w_final),
    .busy_o         (busy_o),
    .sampler_stop_o (sampler_stop_o)
  );

  // Output register stage: address and data are forced to 0 on idle cycles
  // so the memory bus never shows stale values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      poly_done_o <= 1'b0;
      done_o      <= 1'b0;
    end else if (zeroize) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      poly_done_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      mem_we_o    <= w_accept;
      mem_addr_o  <= w_accept ? w_addr : '0;
      mem_wdata_o <= w_accept ? data_i : '0;
      poly_done_o <= w_last_word;
      done_o      <= w_final;
    end
  end

endmodule : abr_sample_mem_writer
`default_nettype wire

// File: tb/tb_abr_sample_mem_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_abr_sample_mem_writer
// Description : Self-checking scoreboard bench for abr_sample_mem_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_abr_sample_mem_writer;

  localparam int NUM_RD = 4;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 10;
  localparam int CPP    = 256;
  localparam int WPP    = CPP / NUM_RD;
  localparam int DW     = NUM_RD * DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
    logic              pd;
    logic              dn;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              zeroize;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [2:0]        num_poly_i;
  logic              data_valid_i;
  logic [DW-1:0]     data_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DW-1:0]     mem_wdata_o;
  logic              busy_o;
  logic              sampler_stop_o;
  logic              poly_done_o;
  logic              done_o;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   pd_cnt   = 0;
  int   done_cnt = 0;
  bit   exp_run  = 1'b0;
  bit   exp_busy = 1'b0;
  bit   prev_done = 1'b0;

  always #5 clk = ~clk;

  abr_sample_mem_writer #(
    .NUM_RD(NUM_RD), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .COEFF_PER_POLY(CPP)
  ) dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .zeroize        (zeroize),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .num_poly_i     (num_poly_i),
    .data_valid_i   (data_valid_i),
    .data_i         (data_i),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .busy_o         (busy_o),
    .sampler_stop_o (sampler_stop_o),
    .poly_done_o    (poly_done_o),
    .done_o         (done_o)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every write, checks idle bus otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst_b) begin
      check("sampler_stop", sampler_stop_o, !exp_run);
      check("busy", busy_o, exp_busy);
      if (prev_done) check("busy_after_done", busy_o, 0);
      if (mem_we_o) begin
        if (q.size() == 0) begin
          check("unexpected_we", 1, 0);
        end else begin
          e = q.pop_front();
          check("addr", mem_addr_o, e.addr);
          check("wdata", mem_wdata_o, e.data);
          check("poly_done", poly_done_o, e.pd);
          check("done", done_o, e.dn);
        end
        if (poly_done_o) pd_cnt++;
        if (done_o) done_cnt++;
      end else begin
        check("idle_addr", mem_addr_o, 0);
        check("idle_wdata", mem_wdata_o, 0);
        check("idle_poly_done", poly_done_o, 0);
        check("idle_done", done_o, 0);
      end
      prev_done = done_o;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Drives one run; zero_at >= 0 asserts zeroize in place of that word.
  task automatic do_run(input logic [ADDR_W-1:0] base, input logic [2:0] np,
                        input bit gaps, input int zero_at);
    int total;
    int n;
    logic [ADDR_W-1:0] a;
    exp_t e;
    total = (int'(np) + 1) * WPP;
    n = 0;
    a = base;
    start_i = 1'b1; base_addr_i = base; num_poly_i = np; data_valid_i = 1'b0;
    tick();
    start_i = 1'b0; base_addr_i = '0; num_poly_i = '0;
    exp_run = 1'b1; exp_busy = 1'b1;
    while (n < total) begin
      data_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      data_i = {$urandom, $urandom, $urandom};
      if (n == zero_at) begin
        zeroize = 1'b1; data_valid_i = 1'b1;
        tick();
        zeroize = 1'b0; data_valid_i = 1'b0;
        exp_run = 1'b0; exp_busy = 1'b0;
        return;
      end
      if (data_valid_i) begin
        e.addr = a; e.data = data_i;
        e.pd = ((n % WPP) == WPP - 1);
        e.dn = (n == total - 1);
        q.push_back(e);
        a = a + 1'b1;
        n++;
      end
      tick();
    end
    // Now in DONE: this valid word must be dropped.
    exp_run = 1'b0;
    data_valid_i = 1'b1; data_i = {$urandom, $urandom, $urandom};
    tick();
    data_valid_i = 1'b0;
    exp_busy = 1'b0;
    tick();
  endtask

  initial begin
    int pd0, dn0;
    rst_b = 1'b0; zeroize = 1'b0; start_i = 1'b0; base_addr_i = '0;
    num_poly_i = '0; data_valid_i = 1'b0; data_i = '0;
    repeat (3) tick();
    check("rst_we", mem_we_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_poly_done", poly_done_o, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_sampler_stop", sampler_stop_o, 1);
    rst_b = 1'b1;
    tick();

    // Valid words in IDLE are dropped.
    data_valid_i = 1'b1;
    repeat (4) begin data_i = {$urandom, $urandom, $urandom}; tick(); end
    data_valid_i = 1'b0;
    tick();

    // One polynomial, back-to-back.
    pd0 = pd_cnt; dn0 = done_cnt;
    do_run(10'h010, 3'd0, 1'b0, -1);
    check("run1_pd_count", pd_cnt - pd0, 1);
    check("run1_done_count", done_cnt - dn0, 1);
    check("run1_queue_empty", q.size(), 0);

    // Three polynomials with random gaps.
    pd0 = pd_cnt; dn0 = done_cnt;
    do_run(10'h100, 3'd2, 1'b1, -1);
    check("run2_pd_count", pd_cnt - pd0, 3);
    check("run2_done_count", done_cnt - dn0, 1);
    check("run2_queue_empty", q.size(), 0);

    // Address wrap-around.
    pd0 = pd_cnt; dn0 = done_cnt;
    do_run(10'h3F0, 3'd0, 1'b0, -1);
    check("wrap_done_count", done_cnt - dn0, 1);
    check("wrap_queue_empty", q.size(), 0);

    // Zeroize at word 30, then a fresh run.
    do_run(10'h200, 3'd0, 1'b0, 30);
    check("zero_we", mem_we_o, 0);
    check("zero_addr", mem_addr_o, 0);
    check("zero_wdata", mem_wdata_o, 0);
    check("zero_busy", busy_o, 0);
    check("zero_sampler_stop", sampler_stop_o, 1);
    check("zero_queue_empty", q.size(), 0);
    tick();
    pd0 = pd_cnt; dn0 = done_cnt;
    do_run(10'h050, 3'd0, 1'b1, -1);
    check("after_zero_pd_count", pd_cnt - pd0, 1);
    check("after_zero_done_count", done_cnt - dn0, 1);
    check("after_zero_queue_empty", q.size(), 0);

    // Asynchronous reset mid-run.
    start_i = 1'b1; base_addr_i = 10'h080; num_poly_i = 3'd1;
    tick();
    start_i = 1'b0; exp_run = 1'b1; exp_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      data_valid_i = 1'b1; data_i = {$urandom, $urandom, $urandom};
      e.addr = 10'h080 + 10'(i); e.data = data_i; e.pd = 1'b0; e.dn = 1'b0;
      q.push_back(e);
      tick();
    end
    check("pre_reset_we", mem_we_o, 1);
    #2;
    rst_b = 1'b0;
    #1;
    check("async_rst_we", mem_we_o, 0);
    check("async_rst_addr", mem_addr_o, 0);
    check("async_rst_wdata", mem_wdata_o, 0);
    check("async_rst_busy", busy_o, 0);
    q.delete();
    exp_run = 1'b0; exp_busy = 1'b0;
    tick(); tick();
    rst_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_valid_i = 1'($urandom_range(0, 1));
      data_i = {$urandom, $urandom, $urandom};
      tick();
    end
    data_valid_i = 1'b0;
    tick();
    check("final_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_abr_sample_mem_writer
`default_nettype wire

// File: doc/abr_sample_mem_writer.md
# abr_sample_mem_writer

Downstream consumer of `abr_sample_buffer`. It accepts the buffer's packed `NUM_RD`-coefficient output words and writes them into polynomial memory at consecutive addresses. It counts complete polynomials and tells the upstream sampler when to stop. The buffer output has no ready signal, so this block accepts every valid word presented while running.

## Interface
- `NUM_RD`, 4: coefficients per input word, equal to the buffer's `NUM_RD`.
- `DATA_W`, 24: coefficient width.
- `ADDR_W`, 10: memory address width.
- `COEFF_PER_POLY`, 256: coefficients per polynomial. Must be a multiple of `NUM_RD`.
- `clk`  in  1  clock
- `rst_b`  in  1  asynchronous, active-low reset
- `zeroize`  in  1  synchronous clear, overrides everything
- `start_i`  in  1  begin a run; sampled only in IDLE
- `base_addr_i`  in  ADDR_W  first write address, captured on start
- `num_poly_i`  in  3  polynomials to produce minus one (0 = 1 poly, 7 = 8)
- `data_valid_i`  in  1  input word valid (buffer `data_valid_o`)
- `data_i`  in  NUM_RD×DATA_W  packed coefficients, lane 0 = oldest
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`  out  ADDR_W  write address
- `mem_wdata_o`  out  NUM_RD×DATA_W  write data, `data_i` unchanged
- `busy_o`  out  1  FSM not IDLE
- `sampler_stop_o`  out  1  upstream must stop producing samples
- `poly_done_o`  out  1  one-cycle pulse per completed polynomial
- `done_o`  out  1  one-cycle pulse at end of run

## Operation
- Constant: `WORDS_PER_POLY = COEFF_PER_POLY/NUM_RD` (64 at defaults).
- Word counter width is `$clog2(WORDS_PER_POLY)`; poly counter width is 3; address register width is `ADDR_W`.
- FSM states and transitions:
  - IDLE → RUN on `start_i`. Captures `base_addr_i` into the address register and `num_poly_i` into the poly limit. Clears both counters.
  - RUN: on each `data_valid_i`:
    - Registers `data_i` and the current address into the output stage.
    - Increments the address, wrapping modulo 2^ADDR_W.
    - Increments the word counter.
  - Word counter at `WORDS_PER_POLY-1` with `data_valid_i`: word counter → 0, poly counter +1, `poly_done_o` pulses next cycle.
  - Final word of the final polynomial accepted: RUN → DONE.
  - DONE → IDLE unconditionally after one cycle.
- `data_valid_i` in IDLE or DONE is dropped: no write, no counter change.
- `start_i` in RUN or DONE is ignored.
- `sampler_stop_o` = state ≠ RUN.
- `zeroize`: FSM → IDLE; counters, address register and every output register → 0 on the next edge. Any in-flight write is discarded.

## Timing
- Reset value of every output is 0; FSM resets to IDLE.
- Write latency is 1: `data_valid_i` at cycle N gives `mem_we_o`, `mem_addr_o` and `mem_wdata_o` at N+1.
- `mem_addr_o` and `mem_wdata_o` are 0 whenever `mem_we_o` is 0.
- `poly_done_o` is aligned with the `mem_we_o` of that polynomial's last word.
- `done_o` is high in DONE, aligned with the final `mem_we_o`. It coincides with the last `poly_done_o`.
- `busy_o` rises the cycle after `start_i` and falls the cycle after `done_o`.
- Back-to-back valid every cycle gives one write per cycle with no bubbles.
- Address wrap-around (0x3FF → 0x000) is silent and does not end the run.
- A run takes at least 2 + (num_poly_i+1)×WORDS_PER_POLY cycles from `start_i` to `done_o`.
- `start_i` coinciding with `zeroize` is ignored.

## Structure
- `abr_params_pkg` holds:
  - the FSM state enum (`SMW_IDLE`, `SMW_RUN`, `SMW_DONE`);
  - the `COEFF_PER_POLY` default;
  - the coefficient typedef `coeff_t` of width DATA_W.
- Sub-module: `abr_sample_mem_writer_ctrl` holds the FSM and counters. The top level holds the output register stage. A single flat module is also acceptable.

## Test plan
- Start with base 0x010, num_poly 0, then 64 consecutive valid words → 64 writes at 0x010–0x04F, each with data equal to its input word. `poly_done_o` and `done_o` both fire with the write to 0x04F; `busy_o` is low the next cycle.
- Start with num_poly 2 and random valid gaps → exactly 192 writes and three `poly_done_o` pulses (after writes 64, 128 and 192). `done_o` fires once, with the third.
- Base 0x3F0, one poly → addresses 0x3F0–0x3FF, then 0x000–0x02F; run completes normally.
- Valid words in IDLE before start and in DONE → no `mem_we_o`. `sampler_stop_o` is 1 in both states and 0 throughout RUN.
- `zeroize` asserted at word 30 → all outputs 0 the next cycle, FSM in IDLE. A new start then writes from the new base with counters at 0.
- `rst_b` asserted asynchronously mid-run → outputs 0 immediately. After release, no writes occur until `start_i`.
